l2_way_array: RTL
=================

# l2_way_array

Parametrised multi-way data store for the L2 cache: WAYS independent banks of DEPTH entries × WIDTH bits, sharing one set index. Adds byte-enabled writes, a registered read with valid strobe, and a hardware clear sweep with a ready handshake. Sits under the L2 controller, which issues one read and/or one write per cycle while `ready` is high.

## Interface
- WIDTH, 256, bits per entry; multiple of 8
- DEPTH, 64, entries per way; power of 2, ≥2
- WAYS, 2, number of ways; power of 2, ≥1
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  request a full zeroing sweep
- ready  out  1  high when array accepts rd/wr
- rd  in  1  read all ways at `index`
- wr  in  1  write way `way` at `index`
- way  in  max(1,$clog2(WAYS))  write way select
- index  in  $clog2(DEPTH)  set index for rd and wr
- be  in  WIDTH/8  byte enables; be[i] covers datain[8i+7:8i]
- datain  in  WIDTH  write data
- rvalid  out  1  one-cycle pulse: dataout updated
- dataout  out  WAYS*WIDTH  way w at [w*WIDTH +: WIDTH]

## Operation
- FSM states: CLEAR, IDLE. Sweep pointer `ptr` of $clog2(DEPTH) bits.
- Reset (rst_n low, async): state=CLEAR, ptr=0, ready=0, rvalid=0, dataout=0. Storage itself not reset; the sweep zeroes it.
- CLEAR: each cycle writes 0 to entry `ptr` in every way, ptr++. Write at ptr=DEPTH-1 → IDLE, ptr wraps to 0.
- CLEAR: rd, wr and clear ignored; no rvalid; clear does not restart the sweep.
- IDLE: ready=1. clear=1 → CLEAR next cycle, ptr=0. rd/wr presented with clear in the same cycle are still performed.
- Write (IDLE, wr=1): bytes with be[i]=1 in way `way`, entry `index`, take datain; others unchanged. be=0 → no change. way ≥ WAYS → write dropped.
- Read (IDLE, rd=1): all ways at `index` registered into dataout; rvalid=1 the next cycle only. dataout holds until the next accepted read.
- rd and wr to the same index in one cycle: behaviour per L2_ARRAY_BYPASS_EN.
- rd and wr to different indices: independent.

## Timing
- Read latency 1: rd at edge N → dataout/rvalid valid after edge N+1.
- Write visible to a read issued on the following cycle.
- Sweep: DEPTH cycles. ready rises exactly DEPTH rising edges after rst_n deasserts, or DEPTH+1 edges after a clear is sampled in IDLE.
- rst_n asserted mid-sweep or mid-read: immediate return to reset values; sweep restarts from ptr=0.

## Configuration
- L2_ARRAY_BYPASS_EN defined: same-cycle same-index rd+wr returns merged new data for the written way (write-first); other ways return stored data.
- Undefined: returns pre-write data for all ways (read-first).
- No port or latency change either way.

## Structure
- Package l2_array_pkg: FSM state enum (CLEAR, IDLE), byte-merge function (old, new, be).
- Sub-module l2_array_bank: one way's storage, byte-enabled write, synchronous read port; instantiated WAYS times by generate.
- Top holds FSM, sweep pointer, rvalid register, bypass mux.

## Test plan
- Reset release, WIDTH=256/DEPTH=64/WAYS=2 → ready=0 for 64 cycles, then 1; read every index → all zeros, rvalid one cycle each.
- Write way 1, index 5, be=all ones, datain=0xA5 repeated; read index 5 → way1=0xA5…A5, way0=0.
- Write index 7 with datain=0xFF.. be=all ones, then datain=0x00.., be=0x1 → read byte0=0x00, bytes1-31=0xFF.
- Same-cycle rd+wr index 3 (old 0x11…, new 0x22…): with macro → 0x22…; without → 0x11….
- clear in IDLE after writes → ready low next cycle for 64 cycles, rd ignored (no rvalid), then all entries read 0.
- rst_n asserted at sweep cycle 20 → outputs 0 immediately; after release ready rises after exactly 64 cycles.

Source files
------------

// File: rtl/l2_array_pkg.sv
// l2_array_pkg: shared types and helpers for the L2 way array.
// Optional feature macro used by the top: L2_ARRAY_BYPASS_EN.
package l2_array_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  function automatic logic [7:0] merge_byte(
    input logic [7:0] old_b,
    input logic [7:0] new_b,
    input logic       be
  );
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/l2_array_bank.sv
// l2_array_bank: one way of storage with byte-enabled write
// and a registered read port.
module l2_array_bank
  import l2_array_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int DEPTH = 64,
  localparam int IW = $clog2(DEPTH),
  localparam int NB = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IW-1:0]    widx,
  input  logic [NB-1:0]    be,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IW-1:0]    ridx,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage has no reset; the clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        mem[widx][8*i +: 8] <=
          merge_byte(mem[widx][8*i +: 8],
                     wdata[8*i +: 8], be[i]);
      end
    end
  end

  // Read register samples pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[ridx];
    end
  end

endmodule

// File: rtl/l2_way_array.sv
// l2_way_array: WAYS-bank L2 data store with clear sweep.
// Define L2_ARRAY_BYPASS_EN for write-first same-cycle reads.
module l2_way_array
  import l2_array_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int DEPTH = 64,
  parameter int WAYS  = 2,
  localparam int IW = $clog2(DEPTH),
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int NB = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  ready,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [WW-1:0]         way,
  input  logic [IW-1:0]         index,
  input  logic [NB-1:0]         be,
  input  logic [WIDTH-1:0]      datain,
  output logic                  rvalid,
  output logic [WAYS*WIDTH-1:0] dataout
);

  state_e                state;
  logic [IW-1:0]         ptr;
  logic                  idle;
  logic                  sweep;
  logic                  rd_acc;
  logic [IW-1:0]         widx;
  logic [NB-1:0]         wbe;
  logic [WIDTH-1:0]      wdat;
  logic [WAYS-1:0]       wen;
  logic [WAYS*WIDTH-1:0] rdat;

  assign idle   = (state == IDLE);
  assign sweep  = (state == CLEAR);
  assign rd_acc = idle & rd;
  assign widx   = sweep ? ptr : index;
  assign wbe    = sweep ? '1 : be;
  assign wdat   = sweep ? '0 : datain;

  // Sweep writes every way; normal writes hit one way.
  always_comb begin
    wen = '0;
    for (int w = 0; w < WAYS; w++) begin
      wen[w] = sweep | (idle & wr & (32'(way) == w));
    end
  end

  // Control FSM, sweep pointer, ready and rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CLEAR;
      ptr    <= '0;
      ready  <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          rvalid <= 1'b0;
          ptr    <= ptr + 1'b1;
          if (ptr == IW'(DEPTH - 1)) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          rvalid <= rd;
          if (clear) begin
            state <= CLEAR;
            ptr   <= '0;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    l2_array_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wen[w]),
      .widx  (widx),
      .be    (wbe),
      .wdata (wdat),
      .re    (rd_acc),
      .ridx  (index),
      .rdata (rdat[w*WIDTH +: WIDTH])
    );
  end

`ifdef L2_ARRAY_BYPASS_EN
  logic [WAYS-1:0]  hit;
  logic [NB-1:0]    hbe;
  logic [WIDTH-1:0] hdat;

  // Remember which way was written alongside the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit  <= '0;
      hbe  <= '0;
      hdat <= '0;
    end else if (rd_acc) begin
      hit  <= wen;
      hbe  <= be;
      hdat <= datain;
    end
  end

  // Overlay written bytes onto the read-first data.
  always_comb begin
    dataout = rdat;
    for (int w = 0; w < WAYS; w++) begin
      for (int b = 0; b < NB; b++) begin
        dataout[w*WIDTH + 8*b +: 8] =
          merge_byte(rdat[w*WIDTH + 8*b +: 8],
                     hdat[8*b +: 8],
                     hit[w] & hbe[b]);
      end
    end
  end
`else
  assign dataout = rdat;
`endif

endmodule
